// File: rtl/register_bank_write_arbiter_pkg.sv
// rtl/register_bank_write_arbiter_pkg.sv - shared types, helpers and parameter checks for the register bank write arbiter
//
// Contents:
//   state_t        arbiter FSM state (IDLE, ISSUE)
//   clog2()        ceiling log2 for sizing index vectors
//   ptr_width()    width of a requester index, at least 1 bit
//   params_legal() elaboration-time legality check for the arbiter parameters
package register_bank_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int MinReq  = 2;
    localparam int MaxReq  = 16;
    localparam int MinRegs = 2;
    localparam int MaxRegs = 256;

    function automatic int clog2(input int n);
        int result;
        int value;
        result = 0;
        value  = 1;
        while (value < n) begin
            value  = value * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // The address field must be able to name every register, otherwise
    // part of the bank would be unreachable.
    function automatic bit params_legal(input int num_req,
                                        input int num_regs,
                                        input int addr_width,
                                        input int width);
        return (num_req >= MinReq) && (num_req <= MaxReq) &&
               (num_regs >= MinRegs) && (num_regs <= MaxRegs) &&
               (addr_width >= clog2(num_regs)) &&
               (width >= 1);
    endfunction

endpackage

// File: rtl/register_bank_write_arbiter_rr_priority_picker.sv
// rtl/register_bank_write_arbiter_rr_priority_picker.sv - combinational round-robin priority picker
//
// Picks the first set bit of eligible, searching from rr_ptr upward and
// wrapping modulo Num_Req. Purely combinational; the caller owns rr_ptr.
//
// Ports:
//   eligible   in  Num_Req  candidate requests (already masked by the caller)
//   rr_ptr     in  PtrW     index with highest priority this cycle
//   grant      out Num_Req  one-hot winner, zero when nothing is eligible
//   grant_idx  out PtrW     binary index of the winner, zero when none
//   any_valid  out 1        a winner exists
module rr_priority_picker
    import register_bank_write_arbiter_pkg::*;
#(
    parameter int Num_Req = 4,
    parameter int PtrW    = ptr_width(Num_Req)
) (
    input  logic [Num_Req-1:0] eligible,
    input  logic [PtrW-1:0]    rr_ptr,
    output logic [Num_Req-1:0] grant,
    output logic [PtrW-1:0]    grant_idx,
    output logic               any_valid
);

    // Walk the priority order from lowest to highest priority so that the
    // last hit written is the one closest to rr_ptr.
    always_comb begin
        int pos;
        pos       = 0;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = Num_Req - 1; k >= 0; k--) begin
            pos = (int'(rr_ptr) + k) % Num_Req;
            if (eligible[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                grant_idx  = PtrW'(pos);
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_bank_write_arbiter.sv
// rtl/register_bank_write_arbiter.sv - round-robin write/clear arbiter in front of a shared register bank
//
// Shares one bank of Num_Regs registers (each with sres, ld_en, D inputs)
// among Num_Req requesters. At most one write or clear is issued per cycle.
//
// Ports:
//   clk        in   1                    rising-edge clock
//   ares_n     in   1                    asynchronous active-low reset
//   req        in   Num_Req              per-requester request, held until ack
//   clr        in   Num_Req              1 = clear the addressed register, 0 = write
//   addr       in   Num_Req*Addr_Width   requester i at [i*Addr_Width +: Addr_Width]
//   wdata      in   Num_Req*Width        requester i at [i*Width +: Width]
//   ack        out  Num_Req              one-cycle registered grant/complete pulse
//   addr_err   out  1                    pulses with ack when addr >= Num_Regs
//   reg_ld_en  out  Num_Regs             per-register load enable, one-hot or zero
//   reg_sres   out  Num_Regs             per-register synchronous clear, one-hot or zero
//   reg_D      out  Width                shared register data bus
module register_bank_write_arbiter
    import register_bank_write_arbiter_pkg::*;
#(
    parameter int Width      = 8,
    parameter int Num_Req    = 4,
    parameter int Num_Regs   = 8,
    parameter int Addr_Width = 3
) (
    input  logic                          clk,
    input  logic                          ares_n,
    input  logic [Num_Req-1:0]            req,
    input  logic [Num_Req-1:0]            clr,
    input  logic [Num_Req*Addr_Width-1:0] addr,
    input  logic [Num_Req*Width-1:0]      wdata,
    output logic [Num_Req-1:0]            ack,
    output logic                          addr_err,
    output logic [Num_Regs-1:0]           reg_ld_en,
    output logic [Num_Regs-1:0]           reg_sres,
    output logic [Width-1:0]              reg_D
);

    localparam int PtrW = ptr_width(Num_Req);

    generate
        if (!params_legal(Num_Req, Num_Regs, Addr_Width, Width)) begin : g_illegal_params
            $error("register_bank_write_arbiter: illegal Num_Req/Num_Regs/Addr_Width/Width combination");
        end
    endgenerate

    state_t              state;
    logic [PtrW-1:0]     rr_ptr;

    logic [Num_Req-1:0]  mask;
    logic [Num_Req-1:0]  eligible;
    logic [Num_Req-1:0]  grant;
    logic [PtrW-1:0]     grant_idx;
    logic                any_valid;

    logic [Addr_Width-1:0] sel_addr;
    logic [Width-1:0]      sel_wdata;
    logic                  sel_clr;
    logic                  addr_ok;
    logic [Num_Regs-1:0]   reg_hit;
    logic [PtrW-1:0]       next_ptr;

    // The requester acked in the current cycle completes its handshake at
    // the coming edge, so its still-high req belongs to the finished
    // transaction and must not win again at that edge.
    always_comb begin
        mask     = (state == ISSUE) ? ack : '0;
        eligible = req & ~mask;
    end

    rr_priority_picker #(
        .Num_Req (Num_Req),
        .PtrW    (PtrW)
    ) u_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // Route the winner's transaction fields and decode its target register.
    // Out-of-range addresses decode to no strobe at all.
    always_comb begin
        sel_addr  = addr[grant_idx * Addr_Width +: Addr_Width];
        sel_wdata = wdata[grant_idx * Width +: Width];
        sel_clr   = clr[grant_idx];
        addr_ok   = (32'(sel_addr) < 32'(Num_Regs));
        reg_hit   = '0;
        for (int r = 0; r < Num_Regs; r++) begin
            reg_hit[r] = addr_ok && (32'(sel_addr) == 32'(r));
        end
        next_ptr  = (32'(grant_idx) == 32'(Num_Req - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge ares_n) begin
        if (!ares_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            ack       <= '0;
            addr_err  <= 1'b0;
            reg_ld_en <= '0;
            reg_sres  <= '0;
            reg_D     <= '0;
        end else if (any_valid) begin
            state    <= ISSUE;
            ack      <= grant;
            rr_ptr   <= next_ptr;
            addr_err <= !addr_ok;
            if (sel_clr) begin
                reg_sres  <= reg_hit;
                reg_ld_en <= '0;
                reg_D     <= '0;
            end else begin
                reg_sres  <= '0;
                reg_ld_en <= reg_hit;
                reg_D     <= sel_wdata;
            end
        end else begin
            // reg_D is left alone: with no strobe high nobody samples it.
            state     <= IDLE;
            ack       <= '0;
            addr_err  <= 1'b0;
            reg_ld_en <= '0;
            reg_sres  <= '0;
        end
    end

endmodule

// File: doc/register_bank_write_arbiter.md
Name: register_bank_write_arbiter

Overview:
- Shares one bank of Num_Regs variable-width registers among Num_Req requesters.
- Each register has sres, ld_en and D inputs. The arbiter drives a shared write-data bus plus per-register ld_en and sres strobes.
- Round-robin arbitration; one write or clear per cycle; per-requester req/ack handshake.
- Sits between software/engine write ports and the register bank.

Parameters:
- Width, 8, data width of every register and write port.
- Num_Req, 4, number of requesters (2..16).
- Num_Regs, 8, number of registers in the bank (2..256).
- Addr_Width, 3, register address width; must be >= clog2(Num_Regs).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- ares_n  in  1  asynchronous active-low reset.
- req  in  Num_Req  request per requester; held with addr/wdata/clr stable until acked.
- clr  in  Num_Req  1 = request is a clear (zero) of the addressed register, 0 = write.
- addr  in  Num_Req*Addr_Width  target register, requester i at [i*Addr_Width +: Addr_Width].
- wdata  in  Num_Req*Width  write data, requester i at [i*Width +: Width].
- ack  out  Num_Req  one-cycle grant/complete pulse, registered.
- addr_err  out  1  pulses with ack when the granted addr >= Num_Regs.
- reg_ld_en  out  Num_Regs  per-register load enable, registered, one-hot or zero.
- reg_sres  out  Num_Regs  per-register synchronous clear, registered, one-hot or zero.
- reg_D  out  Width  shared register data bus, registered.

Behaviour:
- Reset (ares_n low, acts immediately):
  - state=IDLE, rr_ptr=0.
  - ack, addr_err, reg_ld_en, reg_sres and reg_D are all 0.
  - Any in-flight transaction is dropped with no ack. After release, first arbitration happens at the first rising edge.
- States: IDLE, ISSUE.
- Arbitration, evaluated at every edge in both states:
  - eligible = req & ~mask, where mask = ack (current grantee excluded, since its handshake completes at this edge). In IDLE, mask = 0.
  - Winner = first eligible index searching rr_ptr, rr_ptr+1, ... with wrap modulo Num_Req.
- If a winner g exists:
  - Go to ISSUE and latch g's addr/clr/wdata into the outputs.
  - ack = one-hot(g); rr_ptr = (g+1) mod Num_Req.
  - If clr[g]: reg_sres[addr]=1, reg_ld_en=0, reg_D=0.
  - Else: reg_ld_en[addr]=1, reg_sres=0, reg_D=wdata[g].
  - If addr >= Num_Regs: no strobe asserted, addr_err=1, ack still issued.
- If no winner: go to IDLE and clear all strobes, ack and addr_err (reg_D keeps its value).
- Latency and handshake:
  - req sampled at edge t gives ack/strobes high during cycle t..t+1.
  - The register captures at edge t+1, and the handshake completes at that same edge.
  - A requester holding req after edge t+1 presents a new transaction.
- Throughput:
  - One transaction per cycle when two or more requesters alternate.
  - A single continuously requesting requester gets every other cycle, because it is masked in the cycle after its grant.
- Fairness: any requester holding req is acked within Num_Req grants.
- At most one bit set across reg_ld_en|reg_sres in any cycle. Strobes never stay asserted for more than one cycle per transaction.
- Dropping req before ack is a protocol violation; the behaviour is undefined and is flagged by a bench assertion only.

Decomposition:
- Shared package:
  - state enum {IDLE, ISSUE}.
  - clog2 function.
  - Parameter-legality checks: Addr_Width >= clog2(Num_Regs), Num_Req >= 2.
- Sub-module rr_priority_picker:
  - Combinational masked round-robin picker.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: one-hot winner, winner index, any_valid.
  - Parameterised by Num_Req; reusable by other arbiters.

Test Plan:
- Reset then a single write: req[0]=1, addr=3, wdata=8'hA5, clr=0 -> next cycle ack=4'b0001, reg_ld_en=8'h08, reg_D=8'hA5; register 3 reads 8'hA5 afterward; state returns to IDLE.
- Round-robin: req=4'b1111 held, all distinct addrs -> ack sequence 0001,0010,0100,1000,0001 on consecutive cycles; no gaps.
- Single persistent requester: req=4'b0100 held, addr incrementing after each ack -> ack[2] high every other cycle; reg_ld_en one-hot each time.
- Clear: req[1]=1, clr[1]=1, addr=5 with register 5=8'h3C -> reg_sres=8'h20, reg_ld_en=0; register 5 reads 0 next cycle.
- Address error: Num_Regs=6, req[3]=1, addr=7 -> ack=4'b1000, addr_err=1, reg_ld_en=reg_sres=0; no register changes.
- Async reset mid-ISSUE: assert ares_n low between edges while ack=0010 -> ack and strobes go 0 immediately; after release with req=4'b0011, first ack is 0001 (rr_ptr=0).
